// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the memory-stage controller.
package mem_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef enum logic [0:0] {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } ms_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: cleared by reset or a low start_i, loads a bubble on request.
module mem_wb_reg #(
    parameter int XLEN = mem_pkg::XLEN,
    parameter int RA_W = mem_pkg::RA_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            bubble_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] read_data_i,
    input  logic            mem_to_reg_i,
    input  logic            reg_write_i,
    input  logic [RA_W-1:0] rd_addr_i,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] read_data_o,
    output logic            mem_to_reg_o,
    output logic            reg_write_o,
    output logic [RA_W-1:0] rd_addr_o
);
    import mem_pkg::*;

    // Pipeline register with clear and bubble insertion
    always_ff @(posedge clk_i) begin
        if (rst_i || !start_i || bubble_i) begin
            alu_result_o <= '0;
            read_data_o  <= '0;
            mem_to_reg_o <= 1'b0;
            reg_write_o  <= 1'b0;
            rd_addr_o    <= '0;
        end else begin
            alu_result_o <= alu_result_i;
            read_data_o  <= read_data_i;
            mem_to_reg_o <= mem_to_reg_i;
            reg_write_o  <= reg_write_i;
            rd_addr_o    <= rd_addr_i;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: runs loads/stores over req/ack, stalls the front end
// while an access is outstanding and feeds the MEM/WB register.
module mem_access_unit #(
    parameter int XLEN = mem_pkg::XLEN,
    parameter int RA_W = mem_pkg::RA_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] ALUResult_i,
    input  logic [XLEN-1:0] RS2data_i,
    input  logic            MemRead_i,
    input  logic            MemWrite_i,
    input  logic            MemtoReg_i,
    input  logic            RegWrite_i,
    input  logic [RA_W-1:0] RDaddr_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            stall_o,
    output logic [XLEN-1:0] ALUResult_o,
    output logic [XLEN-1:0] ReadData_o,
    output logic            MemtoReg_o,
    output logic            RegWrite_o,
    output logic [RA_W-1:0] RDaddr_o,
    output logic [31:0]     stall_cnt_o
);
    import mem_pkg::*;

    ms_state_t       state_q, state_d;
    logic            mem_op_s;
    logic            stall_s;
    logic            launch_s;
    logic            req_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [31:0]     stall_cnt_q;
    logic [XLEN-1:0] wb_rdata_s;

    assign mem_op_s = MemRead_i | MemWrite_i;

    // State register; a low start_i abandons any outstanding access
    always_ff @(posedge clk_i) begin
        if (rst_i || !start_i) begin
            state_q <= MS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            MS_IDLE: begin
                if (mem_op_s) state_d = MS_WAIT;
                else          state_d = MS_IDLE;
            end
            MS_WAIT: begin
                if (mem_ack_i) state_d = MS_IDLE;
                else           state_d = MS_WAIT;
            end
            default: state_d = MS_IDLE;
        endcase
    end

    // Stall and launch decode
    always_comb begin
        stall_s  = 1'b0;
        launch_s = 1'b0;
        case (state_q)
            MS_IDLE: begin
                stall_s  = mem_op_s;
                launch_s = mem_op_s;
            end
            MS_WAIT: begin
                stall_s  = ~mem_ack_i;
                launch_s = 1'b0;
            end
            default: begin
                stall_s  = 1'b0;
                launch_s = 1'b0;
            end
        endcase
    end

    // Request latch: address/data/we held from launch until the next access
    always_ff @(posedge clk_i) begin
        if (rst_i || !start_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (launch_s) begin
            req_q   <= 1'b1;
            we_q    <= MemWrite_i;
            addr_q  <= ALUResult_i;
            wdata_q <= RS2data_i;
        end else if (state_q == MS_WAIT && mem_ack_i) begin
            req_q   <= 1'b0;
        end
    end

    // Stall-cycle counter; start_i low freezes it, only reset clears it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
        end else if (start_i && stall_s) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign wb_rdata_s = (state_q == MS_WAIT && !we_q) ? mem_rdata_i : '0;

    mem_wb_reg #(
        .XLEN (XLEN),
        .RA_W (RA_W)
    ) u_mem_wb_reg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .bubble_i     (stall_s),
        .alu_result_i (ALUResult_i),
        .read_data_i  (wb_rdata_s),
        .mem_to_reg_i (MemtoReg_i),
        .reg_write_i  (RegWrite_i),
        .rd_addr_i    (RDaddr_i),
        .alu_result_o (ALUResult_o),
        .read_data_o  (ReadData_o),
        .mem_to_reg_o (MemtoReg_o),
        .reg_write_o  (RegWrite_o),
        .rd_addr_o    (RDaddr_o)
    );

    assign stall_o     = stall_s;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the bench plays the data memory and
// the upstream pipeline, predicting MEM/WB contents and stall counts.
module tb_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] ALUResult_i;
    logic [31:0] RS2data_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic        MemtoReg_i;
    logic        RegWrite_i;
    logic [4:0]  RDaddr_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic [31:0] ALUResult_o;
    logic [31:0] ReadData_o;
    logic        MemtoReg_o;
    logic        RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] stall_cnt_o;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        m2r;
        logic        rw;
        logic [4:0]  rd;
    } wb_t;

    wb_t         sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_cnt  = 32'd0;

    mem_access_unit dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .ALUResult_i (ALUResult_i),
        .RS2data_i   (RS2data_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .MemtoReg_i  (MemtoReg_i),
        .RegWrite_i  (RegWrite_i),
        .RDaddr_i    (RDaddr_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .ALUResult_o (ALUResult_o),
        .ReadData_o  (ReadData_o),
        .MemtoReg_o  (MemtoReg_o),
        .RegWrite_o  (RegWrite_o),
        .RDaddr_o    (RDaddr_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive_nop();
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        MemtoReg_i  = 1'b0;
        RegWrite_i  = 1'b0;
        ALUResult_i = 32'h0;
        RS2data_i   = 32'h0;
        RDaddr_i    = 5'd0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
    endtask

    task automatic check_bubble(input string tag);
        check_eq({tag, "_wb_rw"}, {63'd0, RegWrite_o}, 64'd0);
        check_eq({tag, "_wb_alu"}, {32'd0, ALUResult_o}, 64'd0);
        check_eq({tag, "_wb_rdata"}, {32'd0, ReadData_o}, 64'd0);
    endtask

    // One instruction through MEM; the bench acks in the k-th WAIT cycle.
    task automatic do_op(input logic rd_en, input logic wr_en, input logic m2r, input logic rw,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                         input int k, input logic [31:0] rdata);
        wb_t e;
        wb_t got;
        MemRead_i   = rd_en;
        MemWrite_i  = wr_en;
        MemtoReg_i  = m2r;
        RegWrite_i  = rw;
        ALUResult_i = alu;
        RS2data_i   = rs2;
        RDaddr_i    = rd;
        mem_ack_i   = 1'b0;
        e.alu   = alu;
        e.rdata = (rd_en && !wr_en) ? rdata : 32'h0;
        e.m2r   = m2r;
        e.rw    = rw;
        e.rd    = rd;
        sb_q.push_back(e);
        #1;
        if (rd_en || wr_en) begin
            check_eq("stall_decode", {63'd0, stall_o}, 64'd1);
            exp_cnt = exp_cnt + 32'd1;
            @(posedge clk_i); #1;
            for (int i = 1; i <= k; i++) begin
                check_eq("req", {63'd0, mem_req_o}, 64'd1);
                check_eq("addr", {32'd0, mem_addr_o}, {32'd0, alu});
                check_eq("we", {63'd0, mem_we_o}, {63'd0, wr_en});
                check_eq("wdata", {32'd0, mem_wdata_o}, {32'd0, rs2});
                check_bubble("wait");
                if (i == k) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = rdata;
                    #1;
                    check_eq("stall_ack", {63'd0, stall_o}, 64'd0);
                end else begin
                    check_eq("stall_wait", {63'd0, stall_o}, 64'd1);
                    exp_cnt = exp_cnt + 32'd1;
                end
                @(posedge clk_i); #1;
            end
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'h0;
            check_eq("req_drop", {63'd0, mem_req_o}, 64'd0);
        end else begin
            check_eq("stall_alu", {63'd0, stall_o}, 64'd0);
            check_eq("req_alu", {63'd0, mem_req_o}, 64'd0);
            @(posedge clk_i); #1;
        end
        got = {ALUResult_o, ReadData_o, MemtoReg_o, RegWrite_o, RDaddr_o};
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq("wb_alu", {32'd0, got.alu}, {32'd0, e.alu});
            check_eq("wb_rdata", {32'd0, got.rdata}, {32'd0, e.rdata});
            check_eq("wb_m2r", {63'd0, got.m2r}, {63'd0, e.m2r});
            check_eq("wb_rw", {63'd0, got.rw}, {63'd0, e.rw});
            check_eq("wb_rd", {59'd0, got.rd}, {59'd0, e.rd});
        end
        check_eq("stall_cnt", {32'd0, stall_cnt_o}, {32'd0, exp_cnt});
    endtask

    initial begin
        drive_nop();
        rst_i   = 1'b1;
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_req", {63'd0, mem_req_o}, 64'd0);
        check_eq("rst_cnt", {32'd0, stall_cnt_o}, 64'd0);
        check_bubble("rst");
        rst_i   = 1'b0;
        start_i = 1'b1;
        @(posedge clk_i); #1;

        // ALU op, zero-wait load, 3-cycle store, back-to-back loads
        do_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd5, 0, 32'h0);
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0, 5'd6, 1, 32'hDEAD_BEEF);
        do_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0000_1234, 5'd0, 3, 32'h5555_AAAA);
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0, 5'd1, 2, 32'h1111_0000);
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'h0, 5'd2, 2, 32'h2222_0004);
        // Read+write together behaves as a store
        do_op(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_00C0, 32'hA5A5_5A5A, 5'd3, 1, 32'h7777_7777);
        do_op(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0, 5'd31, 0, 32'h0);
        drive_nop();

        // Reset during WAIT, then a late ack
        MemRead_i   = 1'b1;
        ALUResult_i = 32'h0000_0100;
        @(posedge clk_i); #1;
        check_eq("mid_req", {63'd0, mem_req_o}, 64'd1);
        drive_nop();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i   = 1'b0;
        exp_cnt = 32'd0;
        check_eq("mid_rst_req", {63'd0, mem_req_o}, 64'd0);
        check_eq("mid_rst_addr", {32'd0, mem_addr_o}, 64'd0);
        check_eq("mid_rst_stall", {63'd0, stall_o}, 64'd0);
        check_eq("mid_rst_cnt", {32'd0, stall_cnt_o}, 64'd0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hCAFE_F00D;
        #1;
        check_eq("late_ack_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk_i); #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        check_bubble("late_ack");
        check_eq("late_ack_req", {63'd0, mem_req_o}, 64'd0);
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0, 5'd9, 2, 32'h0BAD_F00D);

        // start_i low during a load
        MemRead_i   = 1'b1;
        MemtoReg_i  = 1'b1;
        RegWrite_i  = 1'b1;
        RDaddr_i    = 5'd7;
        ALUResult_i = 32'h0000_0200;
        #1;
        check_eq("sl_stall", {63'd0, stall_o}, 64'd1);
        exp_cnt = exp_cnt + 32'd1;
        @(posedge clk_i); #1;
        check_eq("sl_req", {63'd0, mem_req_o}, 64'd1);
        check_eq("sl_addr", {32'd0, mem_addr_o}, 64'h200);
        start_i = 1'b0;
        @(posedge clk_i); #1;
        check_eq("sl_req_drop", {63'd0, mem_req_o}, 64'd0);
        check_eq("sl_addr_clr", {32'd0, mem_addr_o}, 64'd0);
        check_bubble("sl");
        check_eq("sl_cnt", {32'd0, stall_cnt_o}, {32'd0, exp_cnt});
        @(posedge clk_i); #1;
        check_eq("sl_cnt_hold", {32'd0, stall_cnt_o}, {32'd0, exp_cnt});
        drive_nop();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        do_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0033, 32'h0, 5'd4, 0, 32'h0);

        check_eq("sb_drained", {32'd0, 32'(sb_q.size())}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage controller on the consumer side of the EX/MEM pipeline register. It takes the registered EX/MEM fields, runs loads and stores on the data memory over a req/ack handshake, and stalls the front of the pipeline while an access is outstanding. It also owns the MEM/WB pipeline register, so the writeback stage sees either a completed instruction or a bubble.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `RA_W`, 5, register-address width.

Ports:
- `clk_i`  in  1  clock. One clock domain; all state changes on the rising edge.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `start_i`  in  1  pipeline enable. When low, the block behaves as if in reset.
- `ALUResult_i`  in  XLEN  EX/MEM ALU result; memory address for loads and stores.
- `RS2data_i`  in  XLEN  store data.
- `MemRead_i`, `MemWrite_i`, `MemtoReg_i`, `RegWrite_i`  in  1 each  EX/MEM control bits.
- `RDaddr_i`  in  RA_W  destination register.
- `mem_req_o`  out  1  data-memory request.
- `mem_we_o`  out  1  1 = write, 0 = read.
- `mem_addr_o`  out  XLEN  access address.
- `mem_wdata_o`  out  XLEN  write data.
- `mem_ack_i`  in  1  access done; read data valid in the same cycle.
- `mem_rdata_i`  in  XLEN  read data.
- `stall_o`  out  1  holds PC, IF/ID, ID/EX and EX/MEM.
- `ALUResult_o`, `ReadData_o`  out  XLEN  MEM/WB data.
- `MemtoReg_o`, `RegWrite_o`  out  1  MEM/WB control bits.
- `RDaddr_o`  out  RA_W  MEM/WB destination register.
- `stall_cnt_o`  out  32  count of stall cycles since reset.

## Operation
- An instruction is a memory op when `MemRead_i` or `MemWrite_i` is high. If both are high, it is treated as a write.
- FSM states: `MS_IDLE`, `MS_WAIT`.
- `MS_IDLE`, memory op present with `start_i` high:
  - latch `mem_addr_o` = ALUResult_i, `mem_wdata_o` = RS2data_i, `mem_we_o` = MemWrite_i;
  - go to `MS_WAIT`.
  - Non-memory ops stay in `MS_IDLE`.
- `MS_WAIT`:
  - `mem_req_o` = 1; address, data and we held stable.
  - `mem_ack_i` high: go to `MS_IDLE`.
  - `mem_ack_i` low: stay in `MS_WAIT`.
  - `mem_ack_i` is ignored in `MS_IDLE`.
- `stall_o` (combinational) = (`MS_IDLE` and memory op) or (`MS_WAIT` and not `mem_ack_i`). Upstream holds the EX/MEM inputs stable while `stall_o` = 1.
- MEM/WB register update on each edge with `start_i` high:
  - `stall_o` = 1: load a bubble (all outputs 0).
  - `stall_o` = 0: `ALUResult_o`, `MemtoReg_o`, `RegWrite_o` and `RDaddr_o` are taken from the inputs. `ReadData_o` = `mem_rdata_i` if in `MS_WAIT` and the access is a read; otherwise 0.
- `stall_cnt_o` increments by 1 on each edge with `stall_o` = 1 and wraps from 0xFFFF_FFFF to 0.
- Reset, or `start_i` low, on any edge:
  - state → `MS_IDLE`;
  - `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o` = 0;
  - all MEM/WB outputs = 0;
  - `stall_cnt_o` = 0 (reset only; `start_i` low holds the count).
- Reset or `start_i` low in the middle of an access abandons the outstanding request. A late `mem_ack_i` is then ignored.

## Timing
- Non-memory instruction: MEM/WB is valid one edge after it appears on the inputs; no stall.
- Memory instruction, ack after k cycles in `MS_WAIT` (k ≥ 1, ack may arrive in the first WAIT cycle):
  - stall lasts k cycles;
  - MEM/WB captures the result on the edge where ack is sampled;
  - the next instruction appears on the inputs in the following cycle.
- Back-to-back memory ops: the second op enters `MS_WAIT` on the edge after the first ack. There is no idle cycle on the memory bus beyond the one IDLE decode cycle.
- `mem_req_o` deasserts on the edge after ack. The memory must not ack twice for one request.

## Structure
- Shared package `mem_pkg`:
  - `XLEN`, `RA_W` constants;
  - `ms_state_t` enum {`MS_IDLE`, `MS_WAIT`}.
- Sub-module `mem_wb_reg`: plain MEM/WB register with `start_i`/`rst_i` clear and a bubble input. The FSM, request latch, stall logic and counter live in `mem_access_unit`.

## Test plan
- **ALU op.** Add with `RegWrite_i`=1, `ALUResult_i`=0x0000_0010, `RDaddr_i`=5 → next edge: `RegWrite_o`=1, `ALUResult_o`=0x10, `RDaddr_o`=5; `stall_o` never high; `mem_req_o`=0.
- **Load, zero-wait ack.** `MemRead_i`=1, address 0x40; memory acks in the first WAIT cycle with 0xDEAD_BEEF → `stall_o` high for 1 cycle; then `ReadData_o`=0xDEAD_BEEF, `MemtoReg_o`=1; `stall_cnt_o`=1.
- **Store, ack after 3 WAIT cycles.** `MemWrite_i`=1, address 0x80, `RS2data_i`=0x1234 → `mem_we_o`=1, `mem_addr_o`=0x80, `mem_wdata_o`=0x1234 held for 3 cycles; `stall_o` high for 3 cycles; bubbles in MEM/WB during the stall; `ReadData_o`=0 after.
- **Back-to-back loads** to 0x0 and 0x4, each acked after 2 cycles → two separate requests with the correct addresses; both results appear in order; `stall_cnt_o`=4.
- **Reset mid-access.** Pulse `rst_i` in `MS_WAIT`, then assert `mem_ack_i` → state `MS_IDLE`; all outputs 0; late ack ignored (no MEM/WB update, no state change).
- **`start_i` low** during a load → request dropped; outputs 0; `stall_cnt_o` unchanged.
